// File: rtl/rv32i_types.sv
// Shared types for the CDB arbiter: the broadcast entry format, the CDB port
// count, the default functional-unit count and a saturating counter helper.
package rv32i_types;

  localparam int NUM_CDB_PORTS = 2;
  localparam int NUM_FU_CDB    = 4;
  localparam int ROB_IDX_W     = 5;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_entry_idx;
    logic [4:0]           rd_arch;
    logic [31:0]          rd_data;
  } cdb_entry_t;

  // Adds a small increment to a 32-bit counter, sticking at all-ones.
  function automatic logic [31:0] sat_add32(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + 33'(inc);
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// rr_pick2: combinational circular-priority picker returning up to two
// winners. Search order is ptr_i, ptr_i+1, ... wrapping modulo N; the first
// requester found is winner 0 and the next one is winner 1.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt0_o,
  output logic [N-1:0]  gnt1_o,
  output logic          gnt0_vld_o,
  output logic          gnt1_vld_o,
  output logic [PW-1:0] gnt0_idx_o,
  output logic [PW-1:0] gnt1_idx_o
);

  logic [PW-1:0] idx;

  // Walk the requesters in circular order from the pointer, taking the first two.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    gnt0_o     = '0;
    gnt1_o     = '0;
    gnt0_vld_o = 1'b0;
    gnt1_vld_o = 1'b0;
    gnt0_idx_o = '0;
    gnt1_idx_o = '0;
    idx        = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr_i) + off) % N);
      if (req_i[idx]) begin
        if (!gnt0_vld_o) begin
          gnt0_vld_o  = 1'b1;
          gnt0_o[idx] = 1'b1;
          gnt0_idx_o  = idx;
        end else if (!gnt1_vld_o) begin
          gnt1_vld_o  = 1'b1;
          gnt1_o[idx] = 1'b1;
          gnt1_idx_o  = idx;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to two functional-unit results per cycle onto the two
// common data bus ports (cdb, cdb2), round-robin from rr_ptr. Acks are
// combinational in the capture cycle; the payload is broadcast registered in
// the following cycle. A branch mispredict suppresses all acks for that cycle.
// Optional build macro CDB_ARB_PERF_EN adds saturating grant/conflict counters.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU = NUM_FU_CDB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_mispredict,
  input  logic [NUM_FU-1:0] fu_req,
  input  cdb_entry_t        fu_data [NUM_FU],
  output logic [NUM_FU-1:0] fu_ack,
  output cdb_entry_t        cdb,
  output cdb_entry_t        cdb2
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);

  localparam int PW = $clog2(NUM_FU);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  cdb_entry_t    cdb_q, cdb_d;
  cdb_entry_t    cdb2_q, cdb2_d;

  logic [NUM_FU-1:0] gnt0, gnt1;
  logic              gnt0_vld, gnt1_vld;
  logic [PW-1:0]     gnt0_idx, gnt1_idx;
  logic [PW-1:0]     last_idx;
  logic              grant_en;

  rr_pick2 #(.N(NUM_FU), .PW(PW)) u_pick (
    .req_i      (fu_req),
    .ptr_i      (rr_ptr_q),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .gnt0_vld_o (gnt0_vld),
    .gnt1_vld_o (gnt1_vld),
    .gnt0_idx_o (gnt0_idx),
    .gnt1_idx_o (gnt1_idx)
  );

  // Grants are blocked while reset is held (acks must be 0 with no clock) and on a flush.
  assign grant_en = rst & ~branch_mispredict;
  assign fu_ack   = (gnt0 | gnt1) & {NUM_FU{grant_en}};

  // Build next broadcast entries and the next pointer from this cycle's grants.
  always_comb begin
    cdb_d    = '0;
    cdb2_d   = '0;
    rr_ptr_d = rr_ptr_q;
    last_idx = gnt1_vld ? gnt1_idx : gnt0_idx;
    if (grant_en && gnt0_vld) begin
      cdb_d       = fu_data[gnt0_idx];
      cdb_d.valid = 1'b1;
      rr_ptr_d    = (last_idx == PW'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
    end
    if (grant_en && gnt1_vld) begin
      cdb2_d       = fu_data[gnt1_idx];
      cdb2_d.valid = 1'b1;
    end
  end

  // Broadcast registers and round-robin pointer; reset drops any pending payload.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the async reset branch clears everything at once.
    if (!rst) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
      cdb2_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      cdb2_q   <= cdb2_d;
    end
  end

  assign cdb  = cdb_q;
  assign cdb2 = cdb2_q;

`ifdef CDB_ARB_PERF_EN
  logic [31:0] grant_cnt_q, conflict_cnt_q;
  logic        conflict;

  assign conflict = $countones(fu_req) > NUM_CDB_PORTS;

  // Saturating performance counters; only reset clears them, not a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= sat_add32(grant_cnt_q, 2'($countones(fu_ack)));
      conflict_cnt_q <= sat_add32(conflict_cnt_q, {1'b0, conflict});
    end
  end

  assign perf_grant_cnt    = grant_cnt_q;
  assign perf_conflict_cnt = conflict_cnt_q;
`endif

  // Two simultaneous broadcasts must never target the same ROB entry.
  a_cdb_idx_distinct : assert property (@(posedge clk) disable iff (!rst)
    (cdb_q.valid && cdb2_q.valid) |-> (cdb_q.rob_entry_idx != cdb2_q.rob_entry_idx));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter with NUM_FU=4. Inputs are driven on the
// falling edge, acks are checked 1 time unit later, and broadcast outputs are
// checked 1 time unit after the following rising edge.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         branch_mispredict;
  logic [N-1:0] fu_req;
  logic [N-1:0] fu_ack;
  cdb_entry_t   fu_data [N];
  cdb_entry_t   cdb, cdb2;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]  perf_grant_cnt, perf_conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .branch_mispredict (branch_mispredict),
    .fu_req            (fu_req),
    .fu_data           (fu_data),
    .fu_ack            (fu_ack),
    .cdb               (cdb),
    .cdb2              (cdb2)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected broadcast of FU i: its payload with valid forced to 1.
  function automatic cdb_entry_t bcast(input int i);
    cdb_entry_t e;
    e       = fu_data[i];
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic check_bus(input string tag, input cdb_entry_t e0, input cdb_entry_t e1);
    check({tag, " cdb"},  64'(cdb),  64'(e0));
    check({tag, " cdb2"}, 64'(cdb2), 64'(e1));
  endtask

  task automatic check_ptr(input string tag, input logic [1:0] exp);
    check({tag, " rr_ptr"}, 64'(dut.rr_ptr_q), 64'(exp));
  endtask

  // One request cycle: drive, check the combinational ack, advance past the edge.
  task automatic step(input logic [N-1:0] req, input logic bm, input logic [N-1:0] exp_ack,
                      input string tag);
    @(negedge clk);
    fu_req            = req;
    branch_mispredict = bm;
    #1;
    check({tag, " ack"}, 64'(fu_ack), 64'(exp_ack));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rot_ack [3];
    rot_ack[0] = 4'b0011;
    rot_ack[1] = 4'b0101;
    rot_ack[2] = 4'b0110;

    rst               = 1'b0;
    branch_mispredict = 1'b0;
    fu_req            = 4'b1111;
    for (int i = 0; i < N; i++)
      fu_data[i] = '{valid: 1'b0, rob_entry_idx: 5'(10 + i), rd_arch: 5'(i + 1),
                     rd_data: 32'hA000_0000 + 32'(i)};

    // Reset state, including across a clock edge with requests pending.
    #3;
    check("rst ack", 64'(fu_ack), 64'(0));
    check_bus("rst", '0, '0);
    #4;
    check_bus("rst edge", '0, '0);
    check_ptr("rst", 2'd0);
    @(negedge clk);
    rst    = 1'b1;
    fu_req = '0;

    // All four requesting: pairs alternate FU0+1 / FU2+3.
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, 1'b0, (k % 2 == 0) ? 4'b0011 : 4'b1100, $sformatf("all%0d", k));
      if (k % 2 == 0) check_bus($sformatf("all%0d", k), bcast(0), bcast(1));
      else            check_bus($sformatf("all%0d", k), bcast(2), bcast(3));
    end
    check_ptr("all", 2'd0);

    // No requests: both valid bits low.
    step(4'b0000, 1'b0, 4'b0000, "idle");
    check_bus("idle", '0, '0);

    // Lone FU3 with ROB index 5; pointer wraps to 0.
    fu_data[3].rob_entry_idx = 5'd5;
    step(4'b1000, 1'b0, 4'b1000, "fu3");
    check("fu3 cdb idx", 64'(cdb.rob_entry_idx), 64'(5));
    check("fu3 cdb2 valid", 64'(cdb2.valid), 64'(0));
    check_bus("fu3", bcast(3), '0);
    check_ptr("fu3", 2'd0);

    // Move pointer to 3, then 0101 gives FU0 then FU2.
    step(4'b0100, 1'b0, 4'b0100, "fu2");
    check_bus("fu2", bcast(2), '0);
    check_ptr("fu2", 2'd3);
    step(4'b0101, 1'b0, 4'b0101, "p3");
    check_bus("p3", bcast(0), bcast(2));
    check_ptr("p3", 2'd3);

    // Grant FU0+1, then mispredict with the same request.
    step(4'b0011, 1'b0, 4'b0011, "pre");
    check_ptr("pre", 2'd2);
    @(negedge clk);
    fu_req            = 4'b0011;
    branch_mispredict = 1'b1;
    #1;
    check("flush ack", 64'(fu_ack), 64'(0));
    check_bus("flush inflight", bcast(0), bcast(1));
    @(posedge clk);
    #1;
    check_bus("flush", '0, '0);
    check_ptr("flush", 2'd2);

    // Wrapping pair: from pointer 2, FU3 then FU0; pointer follows grant1.
    step(4'b1001, 1'b0, 4'b1001, "wrap");
    check_bus("wrap", bcast(3), bcast(0));
    check_ptr("wrap", 2'd1);

    // Async reset while cdb is valid.
    step(4'b0010, 1'b0, 4'b0010, "fu1");
    check_bus("fu1", bcast(1), '0);
    #2;
    rst = 1'b0;
    #1;
    check_bus("async rst", '0, '0);
    check("async rst ack", 64'(fu_ack), 64'(0));
    check_ptr("async rst", 2'd0);
    @(negedge clk);
    rst    = 1'b1;
    fu_req = '0;
    step(4'b1000, 1'b0, 4'b1000, "post rst");
    check_bus("post rst", bcast(3), '0);
    check_ptr("post rst", 2'd0);
    step(4'b1111, 1'b0, 4'b0011, "post rst all");
    check_bus("post rst all", bcast(0), bcast(1));

`ifdef CDB_ARB_PERF_EN
    @(negedge clk);
    fu_req = '0;
    rst    = 1'b0;
    #1;
    check("perf rst grant", 64'(perf_grant_cnt), 64'(0));
    check("perf rst conflict", 64'(perf_conflict_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++)
      step(4'b0111, 1'b0, rot_ack[k % 3], $sformatf("perf%0d", k));
    check("perf grant", 64'(perf_grant_cnt), 64'(20));
    check("perf conflict", 64'(perf_conflict_cnt), 64'(10));
`endif

    @(negedge clk);
    fu_req = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, number of functional-unit requesters; legal range 2..8.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset; asynchronous and active-low.
REQ-004 Port branch_mispredict  input  1  flush; same cycle the ROB resets head and tail.
REQ-005 Port fu_req  input  NUM_FU  per-FU result-ready request.
REQ-006 Port fu_data  input  NUM_FU x cdb_entry_t  per-FU result payload.
REQ-007 Port fu_ack  output  NUM_FU  per-FU grant; combinational in the capture cycle.
REQ-008 Port cdb  output  cdb_entry_t  registered broadcast port 0, feeds ROB cdb.
REQ-009 Port cdb2  output  cdb_entry_t  registered broadcast port 1, feeds ROB cdb2.

Function
REQ-010 Shall grant at most two requesters per cycle: grant0 to port cdb, grant1 to port cdb2.
REQ-011 Grant search shall be round-robin from pointer rr_ptr (log2 NUM_FU bits): grant0 is the first requesting FU at index rr_ptr, rr_ptr+1, ... mod NUM_FU.
REQ-012 grant1 is the next requesting FU after grant0 in the same circular order; it is never equal to grant0.
REQ-013 fu_ack[i] is 1 in a cycle exactly when FU i holds grant0 or grant1 and branch_mispredict is 0.
REQ-014 Handshake: an FU holds fu_req and fu_data stable until it sees fu_ack; it may drop fu_req only after ack; the arbiter shall not ack a non-requesting FU.
REQ-015 Latency: the payload acked at edge N shall appear on cdb/cdb2 with valid=1 for exactly the cycle after edge N; no payload is ever broadcast twice.
REQ-016 With one grant, cdb carries it and cdb2.valid is 0; with no grants, both valid bits are 0.
REQ-017 The output valid bit shall be forced to 1 from grant, not copied from fu_data.valid; all other fields are copied unchanged.
REQ-018 rr_ptr update on an ack cycle: becomes (index of last granted FU + 1) mod NUM_FU, wrapping at NUM_FU-1 -> 0; otherwise unchanged.
REQ-019 Starvation bound: a continuously requesting FU shall be acked within ceil(NUM_FU/2) cycles.
REQ-020 branch_mispredict=1: no acks that cycle; cdb.valid and cdb2.valid are 0 in the next cycle; rr_ptr is unchanged; in-flight registered results from the previous cycle still broadcast.
REQ-021 Simultaneous request and mispredict: request is not acked; FU is expected to drop the request on the flush.
REQ-022 Assertion (simulation only): cdb.valid & cdb2.valid implies cdb.rob_entry_idx != cdb2.rob_entry_idx.

Reset
REQ-023 Reset asserted: cdb and cdb2 are all-zero (valid=0), rr_ptr=0, fu_ack=0, regardless of clock.
REQ-024 Reset mid-operation discards any registered unbroadcast payload; the first grant after deassertion starts at FU 0.

Configuration
REQ-025 CDB_ARB_PERF_EN defined: add outputs perf_grant_cnt (32 bits, total acks) and perf_conflict_cnt (32 bits, cycles with more than two requests); both saturate at all-ones, clear on reset and do not clear on mispredict.
REQ-026 CDB_ARB_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Structure
REQ-027 cdb_entry_t and NUM_CDB_PORTS=2 belong in rv32i_types; NUM_FU default constant NUM_FU_CDB belongs there too.
REQ-028 One sub-module, rr_pick2: combinational two-winner circular priority picker (req vector, pointer -> two one-hot grants plus valid flags); the top holds registers and pointer.

Verification (NUM_FU=4)
REQ-029 Reset, then fu_req=4'b1111 held 4 cycles: acks FU0+1, FU2+3, FU0+1, FU2+3; cdb/cdb2 follow one cycle later.
REQ-030 Only FU3 requests, rr_ptr=0, rob_entry_idx=5: fu_ack=4'b1000 that cycle; next cycle cdb.valid=1 with idx 5, cdb2.valid=0; rr_ptr becomes 0.
REQ-031 fu_req=4'b0101 with rr_ptr=3: grant0=FU0, grant1=FU2; rr_ptr becomes 3.
REQ-032 fu_req=4'b0011 with branch_mispredict=1: fu_ack=0; both valid bits are 0 next cycle; the prior cycle's grants still broadcast.
REQ-033 Reset asserted asynchronously mid-cycle while cdb.valid=1: cdb.valid drops immediately; after release, fu_req=4'b1000 results in ack to FU3 and rr_ptr becoming 0.
REQ-034 With CDB_ARB_PERF_EN: 10 cycles of fu_req=4'b0111: perf_conflict_cnt=10 and perf_grant_cnt=20.
